// File: rtl/fetch_pkg.sv
// Shared constants and the fetch entry carried from the ROM response to decode.
package fetch_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// Small circular FIFO that absorbs decode stalls; flush discards all entries.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  din_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= din_i;
    end

    // The issue credit rule must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i)
            assert (!(push_i && !pop_i && cnt_q == CW'(DEPTH)))
                else $error("fetch_skid_fifo overflow");
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC and the single in-flight ROM read, feeds decode through a skid FIFO.
module inst_fetch #(
    parameter logic [31:0] RESET_PC     = fetch_pkg::RESET_PC,
    parameter int          DEPTH        = 2,
    parameter logic [31:0] NOP_INST     = fetch_pkg::NOP_INST,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk_50,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d, halted_q, halted_d;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic          deq, issue, resp, zero_hit, push;
    fetch_entry_t  head, din;

    always_comb begin
        mem_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;
        // A redirect voids any head handshake in the same cycle.
        deq      = inst_valid && inst_ready && !redirect_valid;
        occ      = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(deq);
        issue    = redirect_valid || (!halted_q && (occ < (CW+1)'(DEPTH)));
        resp     = inflight_q && !redirect_valid;
        zero_hit = HALT_ON_ZERO && resp && (mem_inst == 32'h0);
        push     = resp && !zero_hit;
        din      = '{inst: mem_inst, pc: req_pc_q};

        pc_d       = issue ? mem_addr + 32'd4 : pc_q;
        req_pc_d   = issue ? mem_addr : req_pc_q;
        inflight_d = issue && !zero_hit;
        halted_d   = halted_q;
        if (redirect_valid) halted_d = 1'b0;
        else if (zero_hit)  halted_d = 1'b1;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

    fetch_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk_50),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (deq),
        .head_o  (head),
        .count_o (count)
    );

    assign inst_valid = (count != '0);
    assign inst_o     = inst_valid ? head.inst : NOP_INST;
    assign pc_o       = inst_valid ? head.pc : 32'h0;
    assign halted     = halted_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch with a behavioural 1-cycle ROM.
module tb_inst_fetch;
    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr, mem_inst, inst_o, pc_o, redirect_pc;
    logic        inst_valid, inst_ready, redirect_valid, halted;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int total = 0;
    int bad   = 0;

    inst_fetch dut (
        .clk_50         (clk_50),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk_50 = ~clk_50;

    // ROM image: distinct nonzero words everywhere except an unpopulated word at 0xA4.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h0000_00A4) ? 32'h0 : (32'hA500_0000 | a);
    endfunction

    always @(posedge clk_50) mem_inst <= rom(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk_50);
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] addr, input logic h);
        chk({tag, " valid"}, 32'(inst_valid), 32'(v));
        chk({tag, " pc"}, pc_o, v ? pc : 32'h0);
        chk({tag, " inst"}, inst_o, v ? rom(pc) : NOP);
        chk({tag, " addr"}, mem_addr, addr);
        chk({tag, " halted"}, 32'(halted), 32'(h));
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        h;
    } vec_t;

    vec_t tbl[33];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic v, input logic [31:0] pc,
                                input logic [31:0] addr, input logic h);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.v = v; r.pc = pc; r.addr = addr; r.h = h;
        return r;
    endfunction

    initial begin
        // cycle 0 = first cycle after reset release
        tbl[0]  = mk(1, 0, 0,      0, 0,      32'h00, 0);
        tbl[1]  = mk(1, 0, 0,      0, 0,      32'h04, 0);
        tbl[2]  = mk(1, 0, 0,      1, 32'h00, 32'h08, 0);
        tbl[3]  = mk(1, 0, 0,      1, 32'h04, 32'h0C, 0);
        tbl[4]  = mk(0, 0, 0,      1, 32'h08, 32'h10, 0);
        tbl[5]  = mk(0, 0, 0,      1, 32'h08, 32'h10, 0);
        tbl[6]  = mk(0, 0, 0,      1, 32'h08, 32'h10, 0);
        tbl[7]  = mk(0, 0, 0,      1, 32'h08, 32'h10, 0);
        tbl[8]  = mk(0, 0, 0,      1, 32'h08, 32'h10, 0);
        tbl[9]  = mk(1, 0, 0,      1, 32'h08, 32'h10, 0);
        tbl[10] = mk(1, 0, 0,      1, 32'h0C, 32'h14, 0);
        tbl[11] = mk(1, 0, 0,      1, 32'h10, 32'h18, 0);
        tbl[12] = mk(0, 0, 0,      1, 32'h14, 32'h1C, 0);
        tbl[13] = mk(0, 1, 32'h46, 1, 32'h14, 32'h44, 0);
        tbl[14] = mk(1, 0, 0,      0, 0,      32'h48, 0);
        tbl[15] = mk(1, 0, 0,      1, 32'h44, 32'h4C, 0);
        tbl[16] = mk(1, 1, 32'h80, 1, 32'h48, 32'h80, 0);
        tbl[17] = mk(1, 0, 0,      0, 0,      32'h84, 0);
        tbl[18] = mk(1, 0, 0,      1, 32'h80, 32'h88, 0);
        tbl[19] = mk(1, 0, 0,      1, 32'h84, 32'h8C, 0);
        tbl[20] = mk(1, 0, 0,      1, 32'h88, 32'h90, 0);
        tbl[21] = mk(1, 0, 0,      1, 32'h8C, 32'h94, 0);
        tbl[22] = mk(1, 0, 0,      1, 32'h90, 32'h98, 0);
        tbl[23] = mk(1, 0, 0,      1, 32'h94, 32'h9C, 0);
        tbl[24] = mk(1, 0, 0,      1, 32'h98, 32'hA0, 0);
        tbl[25] = mk(1, 0, 0,      1, 32'h9C, 32'hA4, 0);
        tbl[26] = mk(1, 0, 0,      1, 32'hA0, 32'hA8, 0);
        tbl[27] = mk(1, 0, 0,      0, 0,      32'hAC, 1);
        tbl[28] = mk(1, 0, 0,      0, 0,      32'hAC, 1);
        tbl[29] = mk(1, 1, 32'h14, 0, 0,      32'h14, 1);
        tbl[30] = mk(1, 0, 0,      0, 0,      32'h18, 0);
        tbl[31] = mk(1, 0, 0,      1, 32'h14, 32'h1C, 0);
        tbl[32] = mk(1, 0, 0,      1, 32'h18, 32'h20, 0);

        rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk_50);
        #1 chk_out("reset", 0, 0, 32'h0, 0);

        for (int i = 0; i < 33; i++) begin
            @(negedge clk_50);
            rst_n          = 1'b1;
            inst_ready     = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            #1;
            chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].pc, tbl[i].addr, tbl[i].h);
        end

        // Redirect landing in the cycle a zero word returns: redirect wins, no halt.
        drive(1, 1, 32'hA0); chk("rz0 addr", mem_addr, 32'hA0);
        drive(1, 0, 0);      chk_out("rz1", 0, 0, 32'hA4, 0);
        drive(1, 1, 32'h30); chk_out("rz2", 1, 32'hA0, 32'h30, 0);
        drive(1, 0, 0);      chk_out("rz3", 0, 0, 32'h34, 0);
        drive(1, 0, 0);      chk_out("rz4", 1, 32'h30, 32'h38, 0);
        drive(1, 0, 0);      chk_out("rz5", 1, 32'h34, 32'h3C, 0);

        // Async reset mid-stream clears outputs without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1 chk_out("arst", 0, 0, 32'h0, 0);
        @(negedge clk_50);
        drive(1, 0, 0); rst_n = 1'b1;
        #1 chk_out("rel0", 0, 0, 32'h00, 0);
        drive(1, 0, 0); chk_out("rel1", 0, 0, 32'h04, 0);
        drive(1, 0, 0); chk_out("rel2", 1, 32'h00, 32'h08, 0);
        drive(1, 0, 0); chk_out("rel3", 1, 32'h04, 32'h0C, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage that drives the PC-indexed read of the synchronous instruction ROM (1-cycle read latency) and delivers instruction/PC pairs to decode over a valid/ready handshake.
- Owns the fetch PC, tracks the single in-flight ROM read, and absorbs decode stalls in a small skid FIFO. Stalls occur, for example, when a multi-cycle matr instruction holds decode.
- Accepts branch/jump redirects from EX and halts on an all-zero (unpopulated) ROM word.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, skid FIFO entries; must be ≥2 for one instruction per cycle.
- NOP_INST, 32'h0000_0013, value on inst_o when no instruction is held.
- HALT_ON_ZERO, 1, if 1, a fetched 32'h0 stops fetching.

Ports:
- clk_50, input, 1, sole clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- mem_addr, output, 32, byte address to the instruction ROM; sampled by the ROM on the rising edge.
- mem_inst, input, 32, ROM read data; corresponds to the mem_addr of the previous cycle.
- inst_valid, output, 1, inst_o/pc_o hold a valid instruction.
- inst_ready, input, 1, decode accepts the head entry this cycle.
- inst_o, output, 32, instruction to decode.
- pc_o, output, 32, byte address of inst_o.
- redirect_valid, input, 1, EX redirect request (taken branch/jump).
- redirect_pc, input, 32, redirect target; bits [1:0] are ignored and forced to 0.
- halted, output, 1, fetch has stopped on a zero word.

Behaviour:
- Reset (async assert, sync release):
  - fetch PC = RESET_PC; FIFO empty; inflight = 0; halted = 0.
  - inst_valid = 0, inst_o = NOP_INST, pc_o = 0, mem_addr = RESET_PC.
- Read latency: an address issued in cycle n returns on mem_inst in cycle n+1. That word is written into the FIFO at the end of cycle n+1 and is visible on inst_o in cycle n+2 at the earliest.
- Issue rule: issue this cycle iff !halted && (count − deq + inflight) < DEPTH, where deq = inst_valid && inst_ready.
  - On issue: inflight_next = 1, req_pc = mem_addr, fetch PC += 4 (wraps modulo 2^32).
  - Otherwise inflight_next = 0 and fetch PC holds.
  - mem_addr is still driven while not issuing; the returned word is ignored.
- Response: when inflight = 1 and the cycle is not a redirect cycle, enqueue {mem_inst, req_pc}.
  - If HALT_ON_ZERO and mem_inst == 0: do not enqueue, set halted, clear inflight.
  - The credit rule guarantees a free FIFO slot; overflow is an assertion failure.
- Output: inst_valid = count > 0. inst_o/pc_o are the head entry, or NOP_INST/0 when empty.
  - While inst_valid && !inst_ready, the outputs stay stable.
  - Enqueue and dequeue in the same cycle are legal; count is unchanged.
- Redirect (highest priority):
  - mem_addr = {redirect_pc[31:2], 2'b00} combinationally in that cycle, which is always an issue cycle. Fetch PC becomes target + 4 and req_pc = target.
  - FIFO is flushed; any head handshake that cycle is void.
  - A response arriving that cycle is discarded; halted clears.
  - Target appears on inst_o 2 cycles after the redirect cycle.
- Back-to-back redirects: the last one wins; each discards the previous in-flight read.
- Redirect in the same cycle a zero word returns: the redirect wins and halted stays 0.
- Halted: no issues; the FIFO still drains normally. Exit only by redirect or reset.
- Reset mid-operation: all state returns to reset values immediately, and the in-flight read is forgotten.

Decomposition:
- Shared package `fetch_pkg`:
  - NOP_INST and RESET_PC constants.
  - fetch entry typedef {inst[31:0], pc[31:0]}.
- Sub-module `fetch_skid_fifo`: DEPTH-entry FIFO with push/pop/flush and count output. The top level holds the PC, inflight, halted, and issue/credit logic.

Test Plan:
- Streaming: ROM 0x00..0x20 hold NOPs plus distinct words, inst_ready=1 → first inst_valid at cycle 2 after reset release with pc_o=0; then one entry per cycle with pc_o = 0, 4, 8, …
- Stall: hold inst_ready=0 for 5 cycles mid-stream → FIFO fills to 2, mem_addr/PC freeze, inst_o stable. On release, pc_o continues with no gap or duplicate.
- Redirect: assert redirect_valid with redirect_pc=0x46 while 2 entries are buffered → mem_addr=0x44 that cycle, inst_valid=0 the next cycle, and inst_o = ROM[0x44] with pc_o = 0x44 the cycle after. Stale words never appear.
- Redirect with simultaneous inst_ready=1 → head not counted as consumed, flush occurs, sequence resumes at the target.
- Halt: fetch reaches address 0xA4 (ROM returns 0) → halted=1 after 0xA0 is enqueued; 0xA0 still delivered, then inst_valid=0. A redirect to 0x14 clears halted and fetch resumes at 0x14.
- Async reset asserted mid-stream with inst_valid=1 → outputs immediately return to reset values; after release, fetch restarts at RESET_PC.
